// File: rtl/intr_sequencer_pkg.sv
// Shared types and defaults for the interrupt / reset-vector sequencer.
package intr_sequencer_pkg;

  typedef enum logic [2:0] {
    StRstRd,
    StRstLd,
    StIdle,
    StDrain,
    StPush,
    StVecRd,
    StVecLd
  } state_e;

  // Bit positions of the flags within ccr_in / ccr_shadow.
  localparam int unsigned CcrZ = 3;
  localparam int unsigned CcrN = 2;
  localparam int unsigned CcrC = 1;
  localparam int unsigned CcrV = 0;

  localparam logic [7:0] RstAddrDefault = 8'h00;
  localparam logic [7:0] VecAddrDefault = 8'h01;

endpackage

// File: rtl/intr_sync.sv
// Multi-flop interrupt synchroniser with rising-edge detect and a single pending latch.
module intr_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic intr_in,
  input  logic clr,
  output logic pending
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pending_q;
  logic              rise;

  assign rise    = sync_q[STAGES-1] & ~prev_q;
  assign pending = pending_q;

  // A new edge in the clear cycle wins, so it is not lost behind the one being retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[STAGES-2:0], intr_in};
      prev_q    <= sync_q[STAGES-1];
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

endmodule

// File: rtl/intr_sequencer.sv
// Reset-vector fetch and interrupt entry/exit sequencer for the 8-bit pipelined core.
module intr_sequencer
  import intr_sequencer_pkg::*;
#(
  parameter int unsigned    DW          = 8,
  parameter logic [DW-1:0]  RST_ADDR    = DW'(RstAddrDefault),
  parameter logic [DW-1:0]  VEC_ADDR    = DW'(VecAddrDefault),
  parameter int unsigned    DRAIN_CYC   = 3,
  parameter int unsigned    SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          intr_in,
  input  logic          pipe_busy,
  input  logic          rti_exec,
  input  logic [DW-1:0] pc_next,
  input  logic [DW-1:0] sp_in,
  input  logic [3:0]    ccr_in,
  input  logic          mem_grant,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          flush_d,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          sp_dec,
  output logic          pc_load,
  output logic [DW-1:0] pc_load_val,
  output logic [3:0]    ccr_shadow,
  output logic          ccr_restore,
  output logic          intr_ack,
  output logic          in_isr
);

  localparam int unsigned CW = $clog2(DRAIN_CYC) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ret_pc_q, ret_pc_d;
  logic [3:0]    shadow_q, shadow_d;
  logic          in_isr_q, in_isr_d;
  logic          pending;
  logic          pend_clr;

  intr_sync #(
    .STAGES (SYNC_STAGES)
  ) u_intr_sync (
    .clk     (clk),
    .reset   (reset),
    .intr_in (intr_in),
    .clr     (pend_clr),
    .pending (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRstRd;
      cnt_q    <= '0;
      ret_pc_q <= '0;
      shadow_q <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ret_pc_q <= ret_pc_d;
      shadow_q <= shadow_d;
      in_isr_q <= in_isr_d;
    end
  end

  assign ccr_shadow = shadow_q;
  assign in_isr     = in_isr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_pc_d    = ret_pc_q;
    shadow_d    = shadow_q;
    in_isr_d    = in_isr_q;
    stall_f     = 1'b1;
    flush_d     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_dec      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    intr_ack    = 1'b0;
    pend_clr    = 1'b0;
    ccr_restore = rti_exec & in_isr_q;
    if (ccr_restore) begin
      in_isr_d = 1'b0;
    end

    unique case (state_q)
      StRstRd: begin
        mem_req  = 1'b1;
        mem_addr = RST_ADDR;
        if (mem_grant) state_d = StRstLd;
      end
      StRstLd: begin
        pc_load     = 1'b1;
        pc_load_val = mem_rdata;
        state_d     = StIdle;
      end
      StIdle: begin
        stall_f = 1'b0;
        if (pending && !in_isr_q && !pipe_busy) begin
          ret_pc_d = pc_next;
          shadow_d = ccr_in;
          cnt_d    = CW'(DRAIN_CYC - 1);
          state_d  = StDrain;
        end
      end
      StDrain: begin
        flush_d = 1'b1;
        if (cnt_q == '0) state_d = StPush;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StPush: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_in;
        mem_wdata = ret_pc_q;
        if (mem_grant) begin
          sp_dec  = 1'b1;
          state_d = StVecRd;
        end
      end
      StVecRd: begin
        mem_req  = 1'b1;
        mem_addr = VEC_ADDR;
        if (mem_grant) state_d = StVecLd;
      end
      StVecLd: begin
        pc_load     = 1'b1;
        pc_load_val = mem_rdata;
        intr_ack    = 1'b1;
        in_isr_d    = 1'b1;
        pend_clr    = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StRstRd;
    endcase

    // Outputs are forced to their idle values for the whole reset assertion.
    if (reset) begin
      stall_f     = 1'b1;
      flush_d     = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      sp_dec      = 1'b0;
      pc_load     = 1'b0;
      pc_load_val = '0;
      intr_ack    = 1'b0;
      ccr_restore = 1'b0;
    end
  end

endmodule

// File: tb/tb_intr_sequencer.sv
// Self-checking bench for intr_sequencer: directed scenarios plus random traffic vs. a step model.
module tb_intr_sequencer;

  localparam int         DRAIN   = 3;
  localparam int         SYNC    = 2;
  localparam logic [7:0] RST_A   = 8'h00;
  localparam logic [7:0] VEC_A   = 8'h01;
  localparam int StepIdle = 2;
  localparam int StepPush = 3 + DRAIN;
  localparam int StepVrd  = 4 + DRAIN;
  localparam int StepVld  = 5 + DRAIN;
  localparam logic [36:0] RESET_VEC = {1'b1, 36'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       intr_in = 1'b0, pipe_busy = 1'b0, rti_exec = 1'b0, mem_grant = 1'b0;
  logic [7:0] pc_next = '0, sp_in = '0, mem_rdata;
  logic [3:0] ccr_in = '0;
  logic       stall_f, flush_d, mem_req, mem_we, sp_dec, pc_load;
  logic       ccr_restore, intr_ack, in_isr;
  logic [7:0] mem_addr, mem_wdata, pc_load_val;
  logic [3:0] ccr_shadow;
  logic [7:0] rst_pc = 8'h20, vec_pc = 8'h80;

  int vectors = 0;
  int miscompares = 0;

  intr_sequencer #(
    .DW (8), .RST_ADDR (RST_A), .VEC_ADDR (VEC_A), .DRAIN_CYC (DRAIN), .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk), .reset (reset), .intr_in (intr_in), .pipe_busy (pipe_busy),
    .rti_exec (rti_exec), .pc_next (pc_next), .sp_in (sp_in), .ccr_in (ccr_in),
    .mem_grant (mem_grant), .mem_rdata (mem_rdata), .stall_f (stall_f), .flush_d (flush_d),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .sp_dec (sp_dec), .pc_load (pc_load), .pc_load_val (pc_load_val),
    .ccr_shadow (ccr_shadow), .ccr_restore (ccr_restore), .intr_ack (intr_ack),
    .in_isr (in_isr)
  );

  always #5 clk = ~clk;

  // Data memory: only the two vector words are readable content.
  always @(posedge clk) begin
    if (mem_req && mem_grant && !mem_we)
      mem_rdata <= (mem_addr == RST_A) ? rst_pc : (mem_addr == VEC_A) ? vec_pc : 8'hEE;
  end

  logic [36:0] dut_vec, exp_vec;
  assign dut_vec = {stall_f, flush_d, mem_req, mem_we, mem_addr, mem_wdata, sp_dec, pc_load,
                    pc_load_val, ccr_shadow, ccr_restore, intr_ack, in_isr};

  // Reference model: a linear step index through the entry script, one step per drain cycle.
  int         step;
  bit         m_pend, m_isr;
  bit         smp [0:SYNC];
  logic [7:0] m_ret;
  logic [3:0] m_shadow;

  task automatic model_reset();
    step = 0; m_pend = 0; m_isr = 0; m_ret = '0; m_shadow = '0;
    for (int i = 0; i <= SYNC; i++) smp[i] = 0;
  endtask

  task automatic model_step();
    int nstep;
    bit edge_seen;
    nstep     = step;
    edge_seen = smp[SYNC-1] && !smp[SYNC];
    if (step == 0 || step == StepPush || step == StepVrd) begin
      if (mem_grant) nstep = step + 1;
    end else if (step == 1 || step == StepVld) begin
      nstep = StepIdle;
    end else if (step == StepIdle) begin
      if (m_pend && !m_isr && !pipe_busy) begin
        nstep = 3; m_ret = pc_next; m_shadow = ccr_in;
      end
    end else begin
      nstep = step + 1;
    end
    if (step == StepVld) m_isr = 1;
    else if (rti_exec && m_isr) m_isr = 0;
    m_pend = (m_pend && step != StepVld) || edge_seen;
    for (int i = SYNC; i > 0; i--) smp[i] = smp[i-1];
    smp[0] = intr_in;
    step = nstep;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  always_comb begin
    logic       e_req, e_pcl;
    logic [7:0] e_addr;
    e_req  = (step == 0) || (step == StepPush) || (step == StepVrd);
    e_pcl  = (step == 1) || (step == StepVld);
    e_addr = (step == 0) ? RST_A : (step == StepPush) ? sp_in : (step == StepVrd) ? VEC_A : 8'h00;
    exp_vec = {step != StepIdle, step >= 3 && step < StepPush, e_req, step == StepPush, e_addr,
               (step == StepPush) ? m_ret : 8'h00, step == StepPush && mem_grant, e_pcl,
               (step == 1) ? rst_pc : (step == StepVld) ? vec_pc : 8'h00, m_shadow,
               rti_exec && m_isr, step == StepVld, m_isr};
    if (reset) exp_vec = RESET_VEC;
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic leave_isr();
    adv(); rti_exec = 1'b1;
    adv(); rti_exec = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      adv(); #1;
      vectors++;
      if (dut_vec !== RESET_VEC) begin
        miscompares++; $display("FAIL reset_state: got %h want %h", dut_vec, RESET_VEC);
      end
    end
  endtask

  task automatic test_reset_fetch();
    rst_pc = 8'h20; mem_grant = 1'b1;
    adv(); reset = 1'b0; #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, RST_A}) begin
      miscompares++; $display("FAIL rst_rd: got %h want %h", {mem_req, mem_we, mem_addr}, 10'h200);
    end
    adv(); #1;
    vectors++;
    if ({pc_load, pc_load_val} !== 9'h120) begin
      miscompares++; $display("FAIL rst_ld: got %h want %h", {pc_load, pc_load_val}, 9'h120);
    end
    adv(); #1;
    vectors++;
    if (dut_vec !== exp_vec || stall_f !== 1'b0) begin
      miscompares++; $display("FAIL rst_idle: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_intr_entry();
    int first_flush = -1, first_load = -1, acks = 0, writes = 0;
    sp_in = 8'hFF; pc_next = 8'h34; ccr_in = 4'b0101; vec_pc = 8'h80;
    mem_grant = 1'b1; pipe_busy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      adv(); intr_in = (c < 3); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL entry c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (flush_d && first_flush < 0) first_flush = c;
      if (pc_load && first_load < 0) first_load = c;
      if (intr_ack) acks++;
      if (mem_req && mem_we && sp_dec) begin
        writes++;
        vectors++;
        if ({mem_addr, mem_wdata} !== 16'hFF34) begin
          miscompares++; $display("FAIL push_data: got %h want ff34", {mem_addr, mem_wdata});
        end
      end
    end
    vectors++;
    if (first_flush !== SYNC + 2 || first_load !== SYNC + DRAIN + 4) begin
      miscompares++;
      $display("FAIL entry_latency: got %0d/%0d want %0d/%0d", first_flush, first_load,
               SYNC + 2, SYNC + DRAIN + 4);
    end
    vectors++;
    if ({acks[3:0], writes[3:0], ccr_shadow, in_isr} !== {4'd1, 4'd1, 4'b0101, 1'b1}) begin
      miscompares++;
      $display("FAIL entry_state: got ack %0d wr %0d ccr %b isr %b want 1 1 0101 1",
               acks, writes, ccr_shadow, in_isr);
    end
  endtask

  task automatic test_rti_merge();
    int acks = 0;
    ccr_in = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      adv(); intr_in = (c == 1 || c == 2 || c == 5 || c == 6); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL merge_wait c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (intr_ack) acks++;
    end
    adv(); rti_exec = 1'b1; #1;
    vectors++;
    if ({ccr_restore, ccr_shadow} !== 5'b1_0101) begin
      miscompares++; $display("FAIL rti_restore: got %b want 10101", {ccr_restore, ccr_shadow});
    end
    adv(); rti_exec = 1'b0; #1;
    vectors++;
    if (in_isr !== 1'b0) begin
      miscompares++; $display("FAIL rti_clear: got %b want 0", in_isr);
    end
    for (int c = 0; c < 14; c++) begin
      adv(); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL merge_entry c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (intr_ack) acks++;
    end
    vectors++;
    if ({acks[3:0], in_isr, ccr_shadow} !== {4'd1, 1'b1, 4'b1010}) begin
      miscompares++;
      $display("FAIL merge_count: got ack %0d isr %b ccr %b want 1 1 1010", acks, in_isr,
               ccr_shadow);
    end
    leave_isr();
  endtask

  task automatic test_busy_hold();
    int flushes = 0, first_load = -1;
    pipe_busy = 1'b1; pc_next = 8'h77; sp_in = 8'hF0;
    for (int c = 0; c < 10; c++) begin
      adv(); intr_in = (c < 2); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL busy_wait c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (flush_d) flushes++;
    end
    vectors++;
    if (flushes !== 0) begin
      miscompares++; $display("FAIL busy_block: got %0d flush cycles want 0", flushes);
    end
    for (int c = 0; c < 10; c++) begin
      adv(); pipe_busy = (c > 1) ? 1'($urandom_range(0, 1)) : 1'b0; #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL busy_run c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (pc_load && first_load < 0) first_load = c;
    end
    vectors++;
    if (first_load !== DRAIN + 3) begin
      miscompares++; $display("FAIL busy_latency: got %0d want %0d", first_load, DRAIN + 3);
    end
    pipe_busy = 1'b0;
    leave_isr();
  endtask

  task automatic test_grant_stall();
    localparam int P = SYNC + DRAIN + 2;
    int first_load = -1;
    sp_in = 8'hC0; pc_next = 8'h5A; pipe_busy = 1'b0;
    for (int c = 0; c < 18; c++) begin
      adv(); intr_in = (c < 2); mem_grant = !(c >= P && c < P + 4); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL grant_wait c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (c >= P && c <= P + 4) begin
        vectors++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, sp_dec} !== {2'b11, 16'hC05A, c == P + 4})
        begin
          miscompares++;
          $display("FAIL push_hold c%0d: got %h want %h", c,
                   {mem_req, mem_we, mem_addr, mem_wdata, sp_dec}, {2'b11, 16'hC05A, c == P + 4});
        end
      end
      if (pc_load && first_load < 0) first_load = c;
    end
    vectors++;
    if (first_load !== P + 6) begin
      miscompares++; $display("FAIL grant_latency: got %0d want %0d", first_load, P + 6);
    end
    mem_grant = 1'b1;
    leave_isr();
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int acks = 0;
    vec_pc = 8'h90;
    for (int c = 0; c < 16 && !hit; c++) begin
      adv(); intr_in = (c < 2); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL mid_seq c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (mem_req && !mem_we && mem_addr == VEC_A) begin
        hit = 1;
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== RESET_VEC) begin
          miscompares++; $display("FAIL mid_async: got %h want %h", dut_vec, RESET_VEC);
        end
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++; $display("FAIL mid_vec_rd: got no VEC_RD want one within 16 cycles");
    end
    adv(); #1;
    vectors++;
    if (dut_vec !== RESET_VEC) begin
      miscompares++; $display("FAIL mid_hold: got %h want %h", dut_vec, RESET_VEC);
    end
    adv(); reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      adv(); #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL mid_after c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (intr_ack) acks++;
    end
    vectors++;
    if ({acks[3:0], in_isr, stall_f} !== 6'b0) begin
      miscompares++; $display("FAIL mid_lost: got ack %0d isr %b stall %b want 0 0 0", acks,
                              in_isr, stall_f);
    end
  endtask

  task automatic test_random();
    rst_pc = 8'($urandom); vec_pc = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      adv();
      reset     = (c % 211 == 150);
      if ($urandom_range(0, 5) == 0) intr_in = ~intr_in;
      pipe_busy = ($urandom_range(0, 2) == 0);
      mem_grant = ($urandom_range(0, 3) != 0);
      rti_exec  = ($urandom_range(0, 11) == 0);
      pc_next   = 8'($urandom);
      sp_in     = 8'($urandom_range(2, 255));
      ccr_in    = 4'($urandom);
      #1;
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++; $display("FAIL random c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_intr_entry();
    test_rti_merge();
    test_busy_hold();
    test_grant_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
